// File: rtl/ed25519_pkg.sv
// Shared field constants, widths and reducer state type for the ed25519 datapath.
package ed25519_pkg;
  localparam int B      = 257;
  localparam int B2     = 514;
  localparam int RW     = 255;
  localparam int FOLD_C = 19;

  localparam logic [254:0] Q =
    255'd57896044618658097711785492504343953926634992332820282019728792003956564819949;
  localparam logic [252:0] L =
    253'd7237005577332262213973186563042994240857116359379907606001950938285454250989;

  typedef enum logic {IDLE, FOLD} state_t;
endpackage

// File: rtl/q_fold_19.sv
// One fold step: lo + FOLD_C*hi, zero-extended to PW. Shift-add form for the 19 case.
module q_fold_19 #(
  parameter int PW     = 514,
  parameter int RW     = 255,
  parameter int FOLD_C = 19
) (
  input  logic [RW-1:0]    lo,
  input  logic [PW-RW-1:0] hi,
  output logic [PW-1:0]    sum
);
  logic [PW-1:0] hx;
  assign hx = PW'(hi);

  generate
    if (FOLD_C == 19) begin : g_shift
      // 19*hi = 16*hi + 2*hi + hi
      assign sum = PW'(lo) + (hx << 4) + (hx << 1) + hx;
    end else begin : g_mul
      assign sum = PW'(lo) + hx * PW'(FOLD_C);
    end
  endgenerate
endmodule

// File: rtl/seq_mod_reduce_q.sv
// Sequential reducer mod q = 2^255-19: fold 2^255 == 19 until hi is zero, then one
// conditional subtract. Define SEQ_REDUCE_FIXED_LAT_EN for constant 3-fold latency.
module seq_mod_reduce_q #(
  parameter int PW     = ed25519_pkg::B2,
  parameter int RW     = ed25519_pkg::RW,
  parameter int FOLD_C = ed25519_pkg::FOLD_C
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] product,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result
);
  import ed25519_pkg::*;

  state_t            st;
  logic [PW-1:0]     x, xf;
  logic [RW-1:0]     lo;
  logic [PW-RW-1:0]  hi;
  logic [1:0]        nfold;
  logic              fin;

  assign hi = x[PW-1:RW];
  assign lo = x[RW-1:0];

  q_fold_19 #(.PW(PW), .RW(RW), .FOLD_C(FOLD_C)) u_fold (
    .lo  (lo),
    .hi  (hi),
    .sum (xf)
  );

`ifdef SEQ_REDUCE_FIXED_LAT_EN
  // Three folds always clear hi for PW=514; a fold with hi=0 leaves x unchanged.
  assign fin = (nfold == 2'd3);
`else
  assign fin = (hi == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      x      <= '0;
      nfold  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          x     <= product;
          nfold <= '0;
          busy  <= 1'b1;
          st    <= FOLD;
        end
        FOLD: if (fin) begin
          result <= (lo >= Q) ? lo - Q : lo;
          done   <= 1'b1;
          busy   <= 1'b0;
          st     <= IDLE;
        end else begin
          x     <= xf;
          nfold <= nfold + 2'd1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mod_reduce_q.sv
// Directed bench for seq_mod_reduce_q: residues, latency, busy/done handshake and async reset.
module tb_seq_mod_reduce_q;
  import ed25519_pkg::*;

  localparam int PW = 514;
  localparam int RW = 255;

`ifdef SEQ_REDUCE_FIXED_LAT_EN
  localparam int LAT0 = 4, LAT1 = 4, LAT2 = 4, LAT3 = 4;
`else
  localparam int LAT0 = 1, LAT1 = 2, LAT2 = 3, LAT3 = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] product = '0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [RW-1:0] result;

  int tests = 0;
  int fails = 0;

  seq_mod_reduce_q dut (
    .clk     (clk),
    .rst     (rst),
    .product (product),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one job, count edges until done, check residue and (optionally) latency.
  task automatic run(input string tag, input logic [PW-1:0] p,
                     input logic [RW-1:0] exp_res, input int exp_lat);
    int cyc;
    @(negedge clk);
    product = p;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " result"}, PW'(result), PW'(exp_res));
    if (exp_lat > 0) chk({tag, " latency"}, PW'(cyc), PW'(exp_lat));
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, PW'(done), PW'(1'b0));
  endtask

  initial begin
    logic [PW-1:0] v;
    logic [RW-1:0] qm1;
    logic          seen;
    int            cyc;

    qm1 = Q - 255'd1;

    // reset state
    #2;
    chk("reset busy",   PW'(busy),   '0);
    chk("reset done",   PW'(done),   '0);
    chk("reset result", PW'(result), '0);
    @(negedge clk);
    rst = 1'b0;

    run("zero",   '0,                '0,  LAT0);
    run("q",      PW'(Q),            '0,  LAT0);
    run("q-1",    PW'(qm1),          qm1, LAT0);
    run("q+5",    PW'(Q) + PW'(5),   255'd5, LAT0);
    run("2q",     PW'(Q) << 1,       '0,  LAT1);
    v = '0; v[255] = 1'b1;
    run("2^255",  v,                 255'd19, LAT1);
    v = '0; v[510] = 1'b1;
    run("2^510",  v,                 255'd361, LAT2);
    run("2^514-1", '1,               255'd5775, LAT3);
    v = PW'(qm1) * PW'(qm1);
    run("(q-1)^2", v,                255'd1, 0);

    // start held through the busy window and the done edge
    @(negedge clk);
    v = '0; v[510] = 1'b1;
    product = v;
    start   = 1'b1;
    @(posedge clk); #1;
    product = '0;
    cyc = 0;
    while (!done && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("busy-hold result",  PW'(result), PW'(361));
    chk("busy-hold latency", PW'(cyc),    PW'(LAT2));
    @(posedge clk); #1;
    chk("done-edge start busy", PW'(busy), '0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("no second done", PW'(seen),   '0);
    chk("result held",    PW'(result), PW'(361));
    run("after hold 2^255-ish", PW'(Q) + PW'(7), 255'd7, LAT0);

    // async reset mid-fold
    @(negedge clk);
    product = '1;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid-fold busy", PW'(busy), PW'(1'b1));
    rst = 1'b1;
    #1;
    chk("async rst busy",   PW'(busy),   '0);
    chk("async rst done",   PW'(done),   '0);
    chk("async rst result", PW'(result), '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("no done after rst", PW'(seen), '0);
    v = '0; v[255] = 1'b1;
    run("post-rst 2^255", v, 255'd19, LAT1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
